// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t     : 32-bit data word.
//   ramstate_t : RAM channel status reported back to the memory controller.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  // Latency counter width; legal latencies are 1..15.
  localparam int unsigned RAM_CNT_W = 4;

endpackage

// File: rtl/ram_store_array.sv
// Word storage behind the RAM responder: DEPTH x 32 array with synchronous
// write, combinational read and synchronous whole-array clear.
// Ports:
//   clk   : rising-edge clock
//   clr   : synchronous clear of every word (takes priority over write)
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : combinational read data
module ram_store_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  word_t         wdata,
  input  logic [IW-1:0] raddr,
  output word_t         rdata
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the CPU-to-RAM request channel. Accepts one
// word read or write at a time and completes it LAT cycles after acceptance.
// Ports:
//   CLK      : rising-edge clock
//   RST      : synchronous active-high reset (also clears storage)
//   ramaddr  : byte address of the request, must be word aligned
//   ramstore : write data (captured at acceptance)
//   ramREN   : read request, held until ACCESS
//   ramWEN   : write request, held until ACCESS
//   ramload  : read data, non-zero only in the ACCESS cycle of a read
//   ramstate : FREE / BUSY / ACCESS / ERROR
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] ramaddr,
  input  logic [31:0]   ramstore,
  input  logic          ramREN,
  input  logic          ramWEN,
  output logic [31:0]   ramload,
  output logic [1:0]    ramstate
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [RAM_CNT_W-1:0] LAT_M1 = RAM_CNT_W'(LAT - 1);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } fsm_t;

  function automatic logic req_legal(input logic [AW-1:0] addr,
                                     input logic ren, input logic wen);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < DEPTH_W) && !(ren && wen);
  endfunction

  fsm_t                 state_q, state_d;
  logic [RAM_CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 op_we_q, op_we_d;
  word_t                data_q, data_d;

  ramstate_t status;
  logic      mem_we;
  word_t     mem_rdata;
  logic      req;
  logic      abort;

  assign req = ramREN | ramWEN;

  // Any departure from the accepted request (dropped, moved, or different
  // operation, including both strobes high) cancels the transaction.
  assign abort = !req || (ramREN && ramWEN) || (ramaddr != addr_q) ||
                 (ramWEN != op_we_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_we_d = op_we_q;
    data_d  = data_q;
    status  = FREE;
    ramload = '0;
    mem_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_legal(ramaddr, ramREN, ramWEN)) begin
            status  = BUSY;
            addr_d  = ramaddr;
            op_we_d = ramWEN;
            data_d  = ramstore;
            cnt_d   = RAM_CNT_W'(1);
            state_d = (LAT == 1) ? S_DONE : S_WAIT;
          end else begin
            status = ERROR;
          end
        end
      end

      S_WAIT: begin
        status = BUSY;
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + RAM_CNT_W'(1);
          if (cnt_q == LAT_M1) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (abort) begin
          status = BUSY;
        end else begin
          status = ACCESS;
          if (op_we_q) begin
            mem_we = 1'b1;
          end else begin
            ramload = mem_rdata;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_we_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_we_q <= op_we_d;
      data_q  <= data_d;
    end
  end

  assign ramstate = status;

  ram_store_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_store (
    .clk   (CLK),
    .clr   (RST),
    .we    (mem_we),
    .waddr (addr_q[IW+1:2]),
    .wdata (data_q),
    .raddr (addr_q[IW+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed vector table on a LAT=2
// instance, hand sequences for reset and for LAT=1 / LAT=15 instances, then
// randomized traffic checked against a cycle-count reference model.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int unsigned LAT_MAIN = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        r0, w0, r1, w1, r2, w2;
  logic [31:0] a0, d0, a1, d1, a2, d2;
  logic [31:0] l0, l1, l2;
  logic [1:0]  s0, s1, s2;

  ram_responder #(.LAT(LAT_MAIN), .DEPTH(1024), .AW(32)) dut (
    .CLK(CLK), .RST(RST), .ramaddr(a0), .ramstore(d0), .ramREN(r0),
    .ramWEN(w0), .ramload(l0), .ramstate(s0));

  ram_responder #(.LAT(1), .DEPTH(1024), .AW(32)) dut1 (
    .CLK(CLK), .RST(RST), .ramaddr(a1), .ramstore(d1), .ramREN(r1),
    .ramWEN(w1), .ramload(l1), .ramstate(s1));

  ram_responder #(.LAT(15), .DEPTH(1024), .AW(32)) dut15 (
    .CLK(CLK), .RST(RST), .ramaddr(a2), .ramstore(d2), .ramREN(r2),
    .ramWEN(w2), .ramload(l2), .ramstate(s2));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: storage plus the accepted transaction and its cycle.
  logic [31:0] mmem [1024];
  bit          m_active;
  int          m_tacc;
  int          cyc;
  logic [31:0] m_addr, m_data;
  logic        m_we;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  st;
    logic [31:0] ld;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] data,
                              input ramstate_t st, input logic [31:0] ld);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.data = data;
    v.st = st; v.ld = ld;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [1:0] gs, input logic [1:0] es,
                       input logic [31:0] gl, input logic [31:0] el);
    n_checks++;
    if (gs !== es) begin
      n_errors++;
      $display("FAIL %s ramstate got=%0d exp=%0d @%0t", name, gs, es, $time);
    end
    n_checks++;
    if (gl !== el) begin
      n_errors++;
      $display("FAIL %s ramload got=%08h exp=%08h @%0t", name, gl, el, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (mmem[i]) mmem[i] = '0;
    m_active = 1'b0;
    m_tacc   = 0;
    m_addr   = '0;
    m_data   = '0;
    m_we     = 1'b0;
  endfunction

  // ACCESS lands exactly LAT cycles after acceptance unless the request
  // changes first; illegal requests report ERROR only from idle.
  function automatic void model_step(input logic ren, input logic wen,
                                     input logic [31:0] addr, input logic [31:0] data,
                                     output logic [1:0] st, output logic [31:0] ld);
    st = FREE;
    ld = '0;
    if (m_active) begin
      if (!(ren || wen) || (ren && wen) || addr != m_addr || wen != m_we) begin
        st = BUSY;
        m_active = 1'b0;
      end else if (cyc - m_tacc == int'(LAT_MAIN)) begin
        st = ACCESS;
        if (m_we) mmem[m_addr[11:2]] = m_data;
        else ld = mmem[m_addr[11:2]];
        m_active = 1'b0;
      end else begin
        st = BUSY;
      end
    end else if (ren || wen) begin
      if (addr[1:0] != 2'b00 || (addr >> 2) >= 32'd1024 || (ren && wen)) begin
        st = ERROR;
      end else begin
        st = BUSY;
        m_active = 1'b1;
        m_tacc = cyc;
        m_addr = addr;
        m_data = data;
        m_we = wen;
      end
    end
  endfunction

  // One clock cycle: drive the selected instance, sample at the falling edge.
  task automatic step(input int sel, input logic rst, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] data,
                      output logic [1:0] st, output logic [31:0] ld,
                      output logic [1:0] mst, output logic [31:0] mld);
    @(posedge CLK);
    #1;
    RST = rst;
    r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    r2 = 1'b0; w2 = 1'b0; a2 = '0; d2 = '0;
    case (sel)
      0: begin r0 = ren; w0 = wen; a0 = addr; d0 = data; end
      1: begin r1 = ren; w1 = wen; a1 = addr; d1 = data; end
      default: begin r2 = ren; w2 = wen; a2 = addr; d2 = data; end
    endcase
    @(negedge CLK);
    case (sel)
      0: begin st = s0; ld = l0; end
      1: begin st = s1; ld = l1; end
      default: begin st = s2; ld = l2; end
    endcase
    if (rst) begin
      model_reset();
      mst = FREE;
      mld = '0;
    end else begin
      model_step(r0, w0, a0, d0, mst, mld);
    end
    cyc++;
  endtask

  initial begin : main
    logic [1:0]  st, mst;
    logic [31:0] ld, mld;
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic [31:0] addr_pool [8];

    RST = 1'b1;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0;
    r1 = 0; w1 = 0; a1 = 0; d1 = 0;
    r2 = 0; w2 = 0; a2 = 0; d2 = 0;
    cyc = 0;
    model_reset();

    step(0, 1'b1, 0, 0, 0, 0, st, ld, mst, mld);
    step(0, 1'b1, 0, 0, 0, 0, st, ld, mst, mld);
    check("reset", st, FREE, ld, 32'h0);

    // Directed vectors (LAT=2).
    add(0, 1, 32'h10, 32'hDEADBEEF, BUSY, 0);
    add(0, 1, 32'h10, 32'hDEADBEEF, BUSY, 0);
    add(0, 1, 32'h10, 32'hDEADBEEF, ACCESS, 0);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(1, 0, 32'h10, 32'h0, BUSY, 0);
    add(1, 0, 32'h10, 32'h0, BUSY, 0);
    add(1, 0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(1, 1, 32'h20, 32'h5, ERROR, 0);
    add(1, 1, 32'h20, 32'h5, ERROR, 0);
    add(1, 0, 32'h20, 32'h0, BUSY, 0);
    add(1, 0, 32'h20, 32'h0, BUSY, 0);
    add(1, 0, 32'h20, 32'h0, ACCESS, 0);
    add(1, 0, 32'h22, 32'h0, ERROR, 0);
    add(0, 1, 32'h1000, 32'h7, ERROR, 0);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(0, 1, 32'h40, 32'h1, BUSY, 0);
    add(0, 0, 32'h0, 32'h0, BUSY, 0);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(1, 0, 32'h40, 32'h0, BUSY, 0);
    add(1, 0, 32'h40, 32'h0, BUSY, 0);
    add(1, 0, 32'h40, 32'h0, ACCESS, 0);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(0, 1, 32'h40, 32'h77, BUSY, 0);
    add(0, 1, 32'h44, 32'h99, BUSY, 0);
    add(0, 1, 32'h44, 32'h99, BUSY, 0);
    add(0, 1, 32'h44, 32'h99, BUSY, 0);
    add(0, 1, 32'h44, 32'h99, ACCESS, 0);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(1, 0, 32'h40, 32'h0, BUSY, 0);
    add(1, 0, 32'h40, 32'h0, BUSY, 0);
    add(1, 0, 32'h40, 32'h0, ACCESS, 0);
    add(1, 0, 32'h44, 32'h0, BUSY, 0);
    add(1, 0, 32'h44, 32'h0, BUSY, 0);
    add(1, 0, 32'h44, 32'h0, ACCESS, 32'h99);
    for (int i = 0; i < 2; i++) begin
      add(1, 0, 32'h10, 32'h0, BUSY, 0);
      add(1, 0, 32'h10, 32'h0, BUSY, 0);
      add(1, 0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF);
    end
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(0, 1, 32'hFFC, 32'hA5A5A5A5, BUSY, 0);
    add(0, 1, 32'hFFC, 32'hA5A5A5A5, BUSY, 0);
    add(0, 1, 32'hFFC, 32'hA5A5A5A5, ACCESS, 0);
    add(1, 0, 32'hFFC, 32'h0, BUSY, 0);
    add(1, 0, 32'hFFC, 32'h0, BUSY, 0);
    add(1, 0, 32'hFFC, 32'h0, ACCESS, 32'hA5A5A5A5);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(0, 1, 32'h80, 32'h11, BUSY, 0);
    add(0, 1, 32'h80, 32'h22, BUSY, 0);
    add(0, 1, 32'h80, 32'h22, ACCESS, 0);
    add(1, 0, 32'h80, 32'h0, BUSY, 0);
    add(1, 0, 32'h80, 32'h0, BUSY, 0);
    add(1, 0, 32'h80, 32'h0, ACCESS, 32'h11);
    add(0, 0, 32'h0, 32'h0, FREE, 0);

    foreach (vq[i]) begin
      step(0, 1'b0, vq[i].ren, vq[i].wen, vq[i].addr, vq[i].data, st, ld, mst, mld);
      check($sformatf("vec%0d", i), st, vq[i].st, ld, vq[i].ld);
    end

    // Reset in the middle of a write.
    step(0, 1'b0, 0, 1, 32'h8, 32'hFF, st, ld, mst, mld);
    check("rstw_acc", st, BUSY, ld, 32'h0);
    step(0, 1'b1, 0, 1, 32'h8, 32'hFF, st, ld, mst, mld);
    step(0, 1'b0, 0, 0, 32'h0, 32'h0, st, ld, mst, mld);
    check("rstw_free", st, FREE, ld, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1'b0, 1, 0, 32'h8, 32'h0, st, ld, mst, mld);
      check($sformatf("rstw_rd%0d", k), st, (k == 2) ? ACCESS : BUSY, ld, 32'h0);
    end
    step(0, 1'b0, 1, 0, 32'h10, 32'h0, st, ld, mst, mld);
    step(0, 1'b0, 1, 0, 32'h10, 32'h0, st, ld, mst, mld);
    step(0, 1'b0, 1, 0, 32'h10, 32'h0, st, ld, mst, mld);
    check("rst_clr_mem", st, ACCESS, ld, 32'h0);

    // LAT=1 instance.
    step(1, 1'b0, 0, 1, 32'h10, 32'h1234, st, ld, mst, mld);
    check("l1_wr0", st, BUSY, ld, 32'h0);
    step(1, 1'b0, 0, 1, 32'h10, 32'h1234, st, ld, mst, mld);
    check("l1_wr1", st, ACCESS, ld, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1'b0, 1, 0, 32'h10, 32'h0, st, ld, mst, mld);
      check($sformatf("l1_rd%0d", k), st, (k % 2 == 1) ? ACCESS : BUSY, ld,
            (k % 2 == 1) ? 32'h1234 : 32'h0);
    end
    step(1, 1'b0, 0, 0, 32'h0, 32'h0, st, ld, mst, mld);
    check("l1_free", st, FREE, ld, 32'h0);

    // LAT=15 instance: ACCESS exactly 15 cycles after acceptance.
    for (int k = 0; k <= 15; k++) begin
      step(2, 1'b0, 0, 1, 32'h4, 32'h55, st, ld, mst, mld);
      check($sformatf("l15_wr%0d", k), st, (k == 15) ? ACCESS : BUSY, ld, 32'h0);
    end
    for (int k = 0; k <= 15; k++) begin
      step(2, 1'b0, 1, 0, 32'h4, 32'h0, st, ld, mst, mld);
      check($sformatf("l15_rd%0d", k), st, (k == 15) ? ACCESS : BUSY, ld,
            (k == 15) ? 32'h55 : 32'h0);
    end
    step(2, 1'b0, 0, 0, 32'h0, 32'h0, st, ld, mst, mld);
    check("l15_free", st, FREE, ld, 32'h0);

    // Randomized traffic on the LAT=2 instance against the model.
    addr_pool[0] = 32'h0;   addr_pool[1] = 32'h4;   addr_pool[2] = 32'h10;
    addr_pool[3] = 32'h40;  addr_pool[4] = 32'h44;  addr_pool[5] = 32'hFFC;
    addr_pool[6] = 32'h22;  addr_pool[7] = 32'h1000;
    cr = 0; cw = 0; ca = 0; cd = 0;
    for (int n = 0; n < 800; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        // hold the current request
      end else if (r < 75) begin
        cd = $urandom;
      end else if (r < 82) begin
        cr = 0; cw = 0;
      end else begin
        int unsigned kind;
        kind = $urandom_range(0, 9);
        cr = (kind == 0) || (kind >= 1 && kind <= 4);
        cw = (kind == 0) || (kind >= 5);
        ca = addr_pool[($urandom_range(0, 99) < 90) ? $urandom_range(0, 5)
                                                     : $urandom_range(6, 7)];
        cd = $urandom;
      end
      if ($urandom_range(0, 199) == 0) begin
        step(0, 1'b1, cr, cw, ca, cd, st, ld, mst, mld);
      end else begin
        step(0, 1'b0, cr, cw, ca, cd, st, ld, mst, mld);
        check($sformatf("rand%0d", n), st, mst, ld, mld);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
Memory-side responder for the CPU-to-RAM request channel driven by memory_control (ramaddr/ramstore/ramREN/ramWEN in; ramload/ramstate out).
- Holds a word-addressed storage array and answers single-word reads and writes after a programmable latency.
- Reports FREE, BUSY, ACCESS and ERROR status exactly as the cache/memory controller expects.
- Sits at the bottom of the single-cycle and pipeline tops; it is the simulation RAM behind the top-level RAM interface.

Parameters:
- LAT, 2, access latency in cycles from request acceptance to ACCESS; legal range 1..15.
- DEPTH, 1024, number of 32-bit words in storage.
- AW, 32, byte-address width.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  reset, synchronous, active-high.
- ramaddr  input  AW  byte address of the request; must be word-aligned.
- ramstore  input  32  write data.
- ramREN  input  1  read request, level-held by the requester until ACCESS.
- ramWEN  input  1  write request, level-held by the requester until ACCESS.
- ramload  output  32  read data; valid only while ramstate==ACCESS for a read.
- ramstate  output  2  ramstate_t status: FREE, BUSY, ACCESS or ERROR.

Behaviour:
- Reset: only one clock, CLK; reset is synchronous and active-high on RST. On RST, the FSM goes to IDLE, the counter clears to 0, the latched address and operation clear, and all DEPTH words clear to 0. Outputs during and after reset with no request: ramstate=FREE, ramload=0.
- Word index: idx = ramaddr[AW-1:2]. The request is illegal if ramaddr[1:0]!=0, if idx>=DEPTH, or if ramREN and ramWEN are both 1.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no request: ramstate=FREE.
- IDLE, legal request: ramstate=BUSY in the same cycle (combinational). Latch the address, operation and store data; cnt=1. Go to WAIT, or go straight to DONE when LAT==1.
- IDLE, illegal request: ramstate=ERROR (combinational). Stay in IDLE. No storage change.
- WAIT: ramstate=BUSY and cnt increments each cycle. When cnt==LAT-1, go to DONE.
- DONE: ramstate=ACCESS for exactly one cycle, which is cycle t+LAT where t is the acceptance cycle.
  - Read in DONE: ramload=mem[idx].
  - Write in DONE: mem[idx]<=latched store data at the CLK edge that ends the ACCESS cycle.
  - Next state is always IDLE. A request still held after ACCESS is treated as a new request and pays the full LAT again.
- Abort in WAIT or DONE: if ramREN and ramWEN both drop, or ramaddr or the operation changes from the latched values, the transaction aborts.
  - The FSM returns to IDLE, no write commits, and ramstate=BUSY for that cycle.
  - A changed but still-asserted request is then re-accepted from IDLE on the next cycle.
- ramstore changing during WAIT is ignored; the store data latched at acceptance is what gets written.
- ramload=0 whenever ramstate!=ACCESS or the operation is a write.
- Counter width is 4 bits; the counter never wraps because the legal LAT is at most 15.
- RST asserted mid-transaction aborts it. No pending write commits, and storage clears.

Decomposition:
- ramstate_t (FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11) and the word typedef live in the shared cpu_types_pkg.
- The FSM state enum and the legality-check function are local to the module.
- One natural sub-module: ram_store_array, a DEPTH x 32 synchronous-write, combinational-read array with synchronous clear.
- The FSM, counter, latches and abort/legality logic stay in ram_responder.

Test Plan (LAT=2, DEPTH=1024 unless noted):
- Write then read: WEN at addr 0x10 with 0xDEADBEEF held. Required: BUSY for 2 cycles, then ACCESS for 1 cycle. Then REN at 0x10 returns ramload=0xDEADBEEF during its ACCESS cycle and 0 on every other cycle.
- Illegal requests:
  - REN and WEN both set at 0x20 → ERROR every cycle; a later read of 0x20 returns 0.
  - Address 0x22 (misaligned) → ERROR.
  - Address 0x1000 (idx=1024) → ERROR.
- Abort: WEN at 0x40 with 0x1, dropped after 1 cycle → no ACCESS; a later read of 0x40 returns 0. WEN at 0x40, then the address switches to 0x44 mid-WAIT → the write commits only at 0x44, with ACCESS 3 cycles after the switch (one abort cycle plus 2 BUSY).
- Back-to-back: REN held continuously at 0x10 → ACCESS repeats every 3 cycles (BUSY, BUSY, ACCESS); with LAT=1 the pattern is BUSY, ACCESS.
- Reset mid-write: RST=1 during WAIT of WEN 0x8 with 0xFF → next cycle ramstate=FREE, ramload=0; a read of 0x8 returns 0.
- Boundary: read of the last word, 0xFFC, after writing 0xA5A5A5A5 returns 0xA5A5A5A5. With LAT=15, ACCESS occurs exactly 15 cycles after acceptance.
